// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter between two byte sources, with a watchdog on tx_done
//   clk_i, reset_i       clock, synchronous active-high reset
//   en_i                 allows new grants (sampled in IDLE only)
//   req_i, data0_i/1_i   per-requester request and byte (0 = echo FIFO, 1 = morse decoder)
//   tx_done_i            transmitter done pulse
//   tx_start_o, tx_data_o start pulse and latched byte to the transmitter
//   ack_o, grant_o       completion pulse and one-hot grantee
//   busy_o, timeout_o    not-IDLE flag and watchdog-abort pulse
module uart_tx_arbiter #(
    parameter int WORD_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 131071,
    parameter int TIMEOUT_BITS   = 17
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 en_i,
    input  logic [1:0]           req_i,
    input  logic [WORD_BITS-1:0] data0_i,
    input  logic [WORD_BITS-1:0] data1_i,
    input  logic                 tx_done_i,
    output logic                 tx_start_o,
    output logic [WORD_BITS-1:0] tx_data_o,
    output logic [1:0]           ack_o,
    output logic [1:0]           grant_o,
    output logic                 busy_o,
    output logic                 timeout_o
);
    typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;
    state_t                  r_state, w_next;
    logic [TIMEOUT_BITS-1:0] r_cnt, w_cnt;
    logic                    r_last, w_last;
    logic                    r_start, w_start;
    logic [WORD_BITS-1:0]    r_data, w_data;
    logic [1:0]              r_ack, w_ack;
    logic [1:0]              r_grant, w_grant;
    logic                    r_busy, w_busy;
    logic                    r_timeout, w_timeout;
    logic                    w_go, w_win, w_done, w_expire;
    assign w_go     = en_i && |req_i;
    // with both requesting, the one not served last wins
    assign w_win    = &req_i ? ~r_last : req_i[1];
    assign w_done   = r_state == WAIT && tx_done_i;
    // tx_done on the final count still wins over the watchdog
    assign w_expire = r_state == WAIT && !tx_done_i && r_cnt == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            r_start   <= 1'b0;
            r_data    <= '0;
            r_ack     <= 2'b00;
            r_grant   <= 2'b00;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt;
            r_last    <= w_last;
            r_start   <= w_start;
            r_data    <= w_data;
            r_ack     <= w_ack;
            r_grant   <= w_grant;
            r_busy    <= w_busy;
            r_timeout <= w_timeout;
        end
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  w_next = w_go ? START : IDLE;
            START: w_next = WAIT;
            WAIT:  w_next = w_done ? ACK : (w_expire ? IDLE : WAIT);
            ACK:   w_next = IDLE;
        endcase
    end
    // next values of the registered outputs
    always_comb begin
        w_start   = r_state == IDLE && w_go;
        w_grant   = w_start ? (w_win ? 2'b10 : 2'b01) : (w_next == IDLE ? 2'b00 : r_grant);
        w_data    = w_start ? (w_win ? data1_i : data0_i) : r_data;
        w_ack     = w_done ? r_grant : 2'b00;
        w_busy    = w_next != IDLE;
        w_timeout = w_expire;
        w_cnt     = r_state == IDLE ? '0 : (r_state == WAIT && !w_done && !w_expire ? r_cnt + 1'b1 : r_cnt);
        w_last    = (r_state == ACK || w_expire) ? r_grant[1] : r_last;
    end
    assign tx_start_o = r_start;
    assign tx_data_o  = r_data;
    assign ack_o      = r_ack;
    assign grant_o    = r_grant;
    assign busy_o     = r_busy;
    assign timeout_o  = r_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       en_i = 1'b1;
    logic [1:0] req_i = 2'b00;
    logic [7:0] data0_i = 8'h00;
    logic [7:0] data1_i = 8'h00;
    logic       tx_done_i = 1'b0;
    logic       tx_start_o;
    logic [7:0] tx_data_o;
    logic [1:0] ack_o;
    logic [1:0] grant_o;
    logic       busy_o;
    logic       timeout_o;
    int         n_checks = 0;
    int         n_fail = 0;
    int         done_delay = 10;
    uart_tx_arbiter #(.WORD_BITS(8), .TIMEOUT_CYCLES(20), .TIMEOUT_BITS(5)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .req_i(req_i),
        .data0_i(data0_i), .data1_i(data1_i), .tx_done_i(tx_done_i),
        .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .ack_o(ack_o),
        .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );
    always #5 clk_i = ~clk_i;
    // transmitter model: tx_done_i high in the cycle done_delay cycles after the tx_start_o cycle; 0 = never
    always begin
        @(negedge clk_i);
        if (tx_start_o === 1'b1 && done_delay > 0) begin
            repeat (done_delay) @(posedge clk_i);
            #1 tx_done_i = 1'b1;
            @(posedge clk_i);
            #1 tx_done_i = 1'b0;
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask
    // called in an IDLE cycle with req_i set; returns in the ACK cycle
    task automatic run_xfer(input string tag, input logic [1:0] g, input logic [7:0] d, input logic drop_en);
        logic [7:0] d0, d1;
        tick;
        chk({tag, " start"}, tx_start_o, 1);
        chk({tag, " grant"}, grant_o, g);
        chk({tag, " data"}, tx_data_o, d);
        chk({tag, " busy"}, busy_o, 1);
        chk({tag, " no_timeout"}, timeout_o, 0);
        if (drop_en) en_i = 1'b0;
        d0 = data0_i;
        d1 = data1_i;
        data0_i = ~d0;
        data1_i = ~d1;
        tick;
        chk({tag, " start_one_cycle"}, tx_start_o, 0);
        repeat (9) tick;
        chk({tag, " ack_early"}, ack_o, 0);
        chk({tag, " grant_held"}, grant_o, g);
        chk({tag, " data_held"}, tx_data_o, d);
        tick;
        chk({tag, " ack"}, ack_o, g);
        chk({tag, " ack_no_timeout"}, timeout_o, 0);
        chk({tag, " ack_busy"}, busy_o, 1);
        data0_i = d0;
        data1_i = d1;
    endtask
    initial begin
        data0_i = 8'h41;
        data1_i = 8'h2E;
        tick;
        tick;
        reset_i = 1'b0;
        chk("rst tx_start", tx_start_o, 0);
        chk("rst tx_data", tx_data_o, 0);
        chk("rst ack", ack_o, 0);
        chk("rst grant", grant_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst timeout", timeout_o, 0);
        // single request
        req_i = 2'b01;
        run_xfer("single", 2'b01, 8'h41, 1'b0);
        req_i = 2'b00;
        tick;
        chk("single idle busy", busy_o, 0);
        chk("single idle grant", grant_o, 0);
        chk("single idle ack", ack_o, 0);
        // watchdog abort on requester 1
        done_delay = 0;
        req_i = 2'b10;
        tick;
        chk("to start", tx_start_o, 1);
        chk("to grant", grant_o, 2'b10);
        repeat (19) begin
            tick;
            chk("to wait ack", {ack_o, timeout_o}, 0);
        end
        tick;
        chk("to not_yet", timeout_o, 0);
        chk("to wait busy", busy_o, 1);
        tick;
        chk("to pulse", timeout_o, 1);
        chk("to ack", ack_o, 0);
        chk("to busy", busy_o, 0);
        chk("to grant_clr", grant_o, 0);
        done_delay = 10;
        req_i = 2'b11;
        run_xfer("post_to", 2'b01, 8'h41, 1'b0);
        req_i = 2'b10;
        tick;
        run_xfer("post_to r1", 2'b10, 8'h2E, 1'b0);
        req_i = 2'b00;
        tick;
        // contention from reset: strict alternation
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
        req_i = 2'b11;
        run_xfer("rr1 r0", 2'b01, 8'h41, 1'b0);
        req_i = 2'b10;
        tick;
        chk("rr gap busy", busy_o, 0);
        run_xfer("rr1 r1", 2'b10, 8'h2E, 1'b0);
        req_i = 2'b11;
        tick;
        run_xfer("rr2 r0", 2'b01, 8'h41, 1'b0);
        req_i = 2'b10;
        tick;
        run_xfer("rr2 r1", 2'b10, 8'h2E, 1'b0);
        req_i = 2'b00;
        tick;
        // tx_done on the final watchdog count
        done_delay = 20;
        req_i = 2'b01;
        tick;
        chk("tie start", tx_start_o, 1);
        repeat (20) tick;
        chk("tie pre ack", ack_o, 0);
        chk("tie pre timeout", timeout_o, 0);
        tick;
        chk("tie ack", ack_o, 2'b01);
        chk("tie timeout", timeout_o, 0);
        req_i = 2'b00;
        tick;
        chk("tie after timeout", timeout_o, 0);
        chk("tie after busy", busy_o, 0);
        // reset during WAIT
        done_delay = 10;
        req_i = 2'b01;
        tick;
        chk("rstw start", tx_start_o, 1);
        repeat (5) tick;
        chk("rstw in wait", busy_o, 1);
        reset_i = 1'b1;
        req_i = 2'b00;
        tick;
        reset_i = 1'b0;
        chk("rstw grant", grant_o, 0);
        chk("rstw busy", busy_o, 0);
        chk("rstw data", tx_data_o, 0);
        chk("rstw start_clr", tx_start_o, 0);
        repeat (12) begin
            tick;
            chk("rstw quiet", {ack_o, timeout_o, busy_o}, 0);
        end
        req_i = 2'b01;
        run_xfer("rstw restart", 2'b01, 8'h41, 1'b0);
        req_i = 2'b00;
        tick;
        // en_i gating
        en_i = 1'b0;
        req_i = 2'b11;
        repeat (50) begin
            tick;
            chk("en0 no start", {tx_start_o, busy_o}, 0);
        end
        en_i = 1'b1;
        req_i = 2'b01;
        run_xfer("en drop", 2'b01, 8'h41, 1'b1);
        req_i = 2'b11;
        tick;
        repeat (20) begin
            tick;
            chk("en0 hold", {tx_start_o, busy_o}, 0);
        end
        en_i = 1'b1;
        tick;
        chk("en1 start", tx_start_o, 1);
        chk("en1 grant", grant_o, 2'b10);
        chk("en1 data", tx_data_o, 8'h2E);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
